// File: rtl/bcd_count_sequencer.sv
// Run controller for a three-digit cascaded BCD counter: prescaled enables,
// counter reset, stop-on-target, and held done/overflow/error status.
module bcd_count_sequencer #(
    parameter int PRESCALE = 4,
    parameter int PW       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic [11:0] target,
    input  logic [3:0]  ones,
    input  logic [3:0]  tens,
    input  logic [3:0]  hundreds,
    input  logic        cnt_done,
    output logic        cnt_enable,
    output logic        cnt_reset,
    output logic        busy,
    output logic        paused,
    output logic        done,
    output logic        overflow,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [11:0]   target_q, target_d;
    logic          en_q, en_d;
    logic          rstn_q, rstn_d;
    logic          busy_q, busy_d;
    logic          paused_q, paused_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;
    logic          err_q, err_d;

    logic [11:0]   count, count_next;
    logic          match, match_next, tgt_ok;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = (v[11:8] != 4'd9) ? v[11:8] + 4'd1 : 4'd0;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [11:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
    endfunction

    assign count  = {hundreds, tens, ones};
    assign match  = (count == target_q);
    assign tgt_ok = bcd_valid(target);

    // cnt_enable is registered, so it is decided one cycle early against the
    // value the counter will show once this cycle's reset/enable has landed.
    always_comb begin
        count_next = count;
        if (!rstn_q) begin
            count_next = '0;
        end else if (en_q) begin
            count_next = bcd_inc(count);
        end
    end
    assign match_next = (count_next == target_q);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        target_d   = target_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        rstn_d     = 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (clear) begin
                    state_d = S_IDLE;
                    rstn_d  = (state_q != S_DONE);
                end else if (!pause && start) begin
                    if (tgt_ok) begin
                        target_d   = target;
                        err_d      = 1'b0;
                        overflow_d = 1'b0;
                        presc_d    = '0;
                        rstn_d     = 1'b0;
                        state_d    = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                presc_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (clear) begin
                    rstn_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (match) begin
                    state_d = S_DONE;
                end else if (cnt_done) begin
                    overflow_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    // The step of this cycle is kept even when pausing, so a
                    // resume never repeats an enable already issued.
                    presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
                    if (pause) begin
                        state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    rstn_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!pause && start) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_d     = (state_d == S_RUN) && (presc_d == PRE_LAST) && !match_next;
        busy_d   = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_PAUSE);
        paused_d = (state_d == S_PAUSE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            target_q   <= '0;
            en_q       <= 1'b0;
            rstn_q     <= 1'b1;
            busy_q     <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            target_q   <= target_d;
            en_q       <= en_d;
            rstn_q     <= rstn_d;
            busy_q     <= busy_d;
            paused_q   <= paused_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    assign cnt_enable = en_q;
    assign cnt_reset  = rstn_q;
    assign busy       = busy_q;
    assign paused     = paused_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Bench for bcd_count_sequencer with a behavioural three-digit BCD counter
// and a scoreboard of expected completions (done cycle, enable count, overflow).
module tb_bcd_count_sequencer;

    localparam int PRESCALE = 4;

    typedef struct {
        int   done_cyc;
        int   n_en;
        logic ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] target = '0;
    logic [11:0] cnt_m = '0;
    logic        cnt_done_m = 1'b0;
    logic        inject_wrap = 1'b0;
    logic        cnt_enable, cnt_reset, busy, paused, done, overflow, err;

    int   cyc = 0;          // number of rising edges seen so far
    int   errors = 0;
    int   checks = 0;
    int   en_cnt = 0;
    int   rst_lo_cnt = 0;
    int   start_cyc = 0;    // cyc value right after the edge that sampled start
    int   p_cyc = 0;
    int   r_cyc = 0;
    logic done_prev = 1'b0;
    int   en_cyc[$];
    exp_t sb[$];

    bcd_count_sequencer #(.PRESCALE(PRESCALE), .PW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .target     (target),
        .ones       (cnt_m[3:0]),
        .tens       (cnt_m[7:4]),
        .hundreds   (cnt_m[11:8]),
        .cnt_done   (cnt_done_m),
        .cnt_enable (cnt_enable),
        .cnt_reset  (cnt_reset),
        .busy       (busy),
        .paused     (paused),
        .done       (done),
        .overflow   (overflow),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] model_inc(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    // Cascaded counter: synchronous active-low reset, advance on enable,
    // cnt_done for one cycle after a wrap; inject_wrap forces an early wrap.
    always @(posedge clk) begin
        cnt_done_m <= 1'b0;
        if (!cnt_reset) begin
            cnt_m <= '0;
        end else if (cnt_enable) begin
            if (inject_wrap || cnt_m == 12'h999) begin
                cnt_m      <= '0;
                cnt_done_m <= 1'b1;
            end else begin
                cnt_m <= model_inc(cnt_m);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int dc, input int n, input logic ovf);
        exp_t e;
        e.done_cyc = dc;
        e.n_en     = n;
        e.ovf      = ovf;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (cnt_enable) begin
            en_cnt++;
            en_cyc.push_back(cyc);
        end
        if (!cnt_reset) rst_lo_cnt++;
        check("en_rst_excl", 32'(cnt_enable & ~cnt_reset), 32'd0);
        if (done && !done_prev) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("done_cyc", cyc, e.done_cyc);
                check("n_enables", en_cnt, e.n_en);
                check("overflow_at_done", 32'(overflow), 32'(e.ovf));
            end
        end
        done_prev = done;
    endtask

    // Accepted start with target N completes 4N+2 edges after the sampling edge.
    task automatic do_start(input logic [11:0] tgt, input bit push, input int n, input logic ovf);
        en_cnt     = 0;
        rst_lo_cnt = 0;
        en_cyc.delete();
        start_cyc = cyc + 1;
        if (push) push_exp(start_cyc + PRESCALE * n + 2, n, ovf);
        target = tgt;
        start  = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic wait_en(input int target_n, input int budget);
        int n;
        n = 0;
        while (en_cnt < target_n && n < budget) begin
            tick();
            n++;
        end
        check("enable_reached", 32'(en_cnt >= target_n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        reset = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'({cnt_enable, cnt_reset, busy, paused, done, overflow, err}), 32'b0100000);
        reset = 1'b1;
        tick();
        check("idle_outputs", 32'({cnt_enable, cnt_reset, busy, paused, done, overflow, err}), 32'b0100000);

        // Target 012: 12 enables spaced PRESCALE apart, stop on 012
        do_start(12'h012, 1'b1, 12, 1'b0);
        check("busy_in_clear", 32'(busy), 32'd1);
        wait_done(200);
        check("t012_en_count", en_cyc.size(), 32'd12);
        for (int k = 0; k < 12 && k < en_cyc.size(); k++) begin
            check("t012_en_cycle", en_cyc[k], start_cyc + PRESCALE * (k + 1));
        end
        check("t012_count", 32'(cnt_m), 32'h012);
        check("t012_rst_pulse", rst_lo_cnt, 32'd1);
        repeat (3) tick();
        check("t012_done_held", 32'({done, busy, overflow}), 32'b100);

        // Target 000: immediate match, no enables
        do_start(12'h000, 1'b1, 0, 1'b0);
        wait_done(20);
        check("t000_rst_pulse", rst_lo_cnt, 32'd1);
        check("t000_count", 32'(cnt_m), 32'h000);

        // Clear from DONE, then invalid target 0A5
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_done", 32'({done, busy, cnt_reset}), 32'b000);
        tick();
        do_start(12'h0A5, 1'b0, 0, 1'b0);
        repeat (6) tick();
        check("bad_err", 32'(err), 32'd1);
        check("bad_idle", 32'({busy, done, paused}), 32'b000);
        check("bad_no_enable", en_cnt, 32'd0);
        check("bad_no_reset", rst_lo_cnt, 32'd0);

        // Target 020 with a 30-cycle pause after 5 counts
        do_start(12'h020, 1'b0, 0, 1'b0);
        check("err_cleared", 32'(err), 32'd0);
        wait_en(5, 100);
        pause = 1'b1;
        tick();
        p_cyc = cyc;
        repeat (29) tick();
        check("pause_flag", 32'({paused, busy}), 32'b11);
        check("pause_no_enable", en_cnt, 32'd5);
        check("pause_count_held", 32'(cnt_m), 32'h005);
        pause = 1'b0;
        r_cyc = cyc + 1;
        push_exp(start_cyc + PRESCALE * 20 + 2 + (r_cyc - p_cyc), 20, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("resume_run", 32'({paused, busy}), 32'b01);
        wait_done(200);
        check("t020_count", 32'(cnt_m), 32'h020);

        // clear + pause + start together mid-run at 007
        do_start(12'h050, 1'b0, 0, 1'b0);
        wait_en(7, 100);
        tick();
        check("at_007", 32'(cnt_m), 32'h007);
        rst_lo_cnt = 0;
        {clear, pause, start} = 3'b111;
        tick();
        {clear, pause, start} = 3'b000;
        check("clr_idle", 32'({busy, done, paused, cnt_reset}), 32'b0000);
        repeat (3) tick();
        check("clr_one_pulse", rst_lo_cnt, 32'd1);
        check("clr_count_zero", 32'(cnt_m), 32'h000);
        check("clr_no_enable", en_cnt, 32'd7);

        // Reset mid-run
        do_start(12'h030, 1'b0, 0, 1'b0);
        wait_en(2, 50);
        reset = 1'b0;
        tick();
        check("midrun_reset", 32'({cnt_enable, cnt_reset, busy, paused, done, overflow, err}), 32'b0100000);
        reset = 1'b1;
        tick();

        // Forced wrap on the 3rd enable with target 999 -> overflow
        do_start(12'h999, 1'b1, 3, 1'b1);
        wait_en(2, 50);
        tick();
        inject_wrap = 1'b1;
        wait_done(50);
        inject_wrap = 1'b0;
        repeat (2) tick();
        check("ovf_sticky", 32'({overflow, done, err}), 32'b110);

        // Restart from DONE with target 003 clears overflow
        do_start(12'h003, 1'b1, 3, 1'b0);
        check("restart_flags", 32'({overflow, done, busy}), 32'b001);
        wait_done(50);
        check("t003_count", 32'(cnt_m), 32'h003);

        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
